oc_led_ctrl: RTL and testbench
==============================

# oc_led_ctrl

Shares the board status LED bank among several on-chip requesters and generates the visible patterns (solid, blink, heartbeat) from the board reference clock. It sits between the chip top's LED output buffers and any number of client blocks. It replaces the free-running counter that drives the LEDs today. With no client requesting, it shows an "alive" heartbeat on LED 0.

## Interface
- `ClockHz`, 156250000, frequency of `clock` in Hz; must be ≥ 2000.
- `LedCount`, 3, number of LEDs driven; 1..8.
- `ClientCount`, 2, number of requesters; 1..8.
- `PwmBits`, 8, width of the brightness control.
- `clock`  in  1  reference clock; all logic on its rising edge.
- `resetN`  in  1  reset; synchronous, active-low.
- `clientReq`  in  ClientCount  client i requests LED ownership while high.
- `clientMode`  in  ClientCount×LedCount×2  per-client, per-LED mode: 0 off, 1 on, 2 blink, 3 heartbeat.
- `clientGrant`  out  ClientCount  one-hot owner indication; all-zero when unowned or in gap.
- `ledBrightness`  in  PwmBits  global brightness for lit LEDs.
- `ledOut`  out  LedCount  to LED OBUFs; high = lit.

## Operation
- Tick generator: `tickCount` counts 0..ClockHz/1000−1. `tick` pulses for one cycle when it reaches the terminal value, then it wraps to 0 (1 ms period).
- Phase counter: increments on `tick` and wraps 999→0 (1 s frame).
- Blink wave is high when phase < 500. Heartbeat wave is high when phase ∈ [0,99] ∪ [200,299].
- Arbitration is fixed priority: the lowest-index requesting client wins.
- Ownership is re-evaluated only on `tick` cycles. Requests that change between ticks have no effect until the next tick.
- State machine states: IDLE, OWN(k), GAP.
- IDLE transitions on `tick`:
  - any request → OWN(winner);
  - otherwise stay in IDLE.
- OWN(k) transitions on `tick`:
  - winner == k → stay;
  - winner ≠ k, or no request → GAP.
- GAP lasts exactly one tick period, with all LEDs off and `clientGrant` = 0.
- GAP exit on the next `tick`:
  - any request → OWN(winner), with the winner evaluated at that tick;
  - otherwise → IDLE.
- LED output by state:
  - IDLE: LED0 = heartbeat, others off.
  - OWN(k): LED j follows `clientMode[k][j]`.
- `clientGrant[k]` is high exactly while in OWN(k).
- Non-owner `clientMode` values are ignored.

## Timing
- Reset values: `ledOut` = 0, `clientGrant` = 0, state IDLE, `tickCount` = 0, phase = 0, PWM counter = 0.
- Reset asserted mid-operation forces these values at the next edge, including during GAP.
- `ledOut` and `clientGrant` are registered.
- A change to the owner's `clientMode` appears on `ledOut` 1 cycle later.
- A state change taken on the `tick` cycle appears on `clientGrant`/`ledOut` on the following cycle.
- Blink and heartbeat edges land on the cycle after the `tick` that moves phase across the boundary.
- Simultaneous `tick` and phase wrap: the arbitration decision uses the pre-wrap state. Phase 0 values apply the cycle after.

## Configuration
- Macro: `OC_LED_CTRL_PWM_EN`.
- Defined:
  - a free-running `PwmBits` counter gates every lit LED;
  - a lit LED is on when counter < `ledBrightness`;
  - `ledBrightness` = all-ones forces solid on;
  - `ledBrightness` = 0 forces off.
- Undefined: no PWM counter is built, `ledBrightness` is ignored, and lit LEDs are solid on.

## Structure
- Package `oc_led_ctrl_pkg` holds:
  - the LED mode enum (`LedModeOff`, `LedModeOn`, `LedModeBlink`, `LedModeHeartbeat`);
  - the state enum (`StIdle`, `StOwn`, `StGap`), with the owner index held in a separate register;
  - localparams for phase limits (1000, 500, 100, 200, 300).
- Sub-module `oc_led_pattern`: tick generator plus phase counter, producing `tick`, `blinkWave` and `heartbeatWave`. Arbitration, the FSM and PWM stay in the top module.

## Test plan
All tests use `ClockHz` = 10000, so `tick` fires every 10 cycles and the frame is 10000 cycles.
- Reset / idle:
  - stimulus: hold `resetN` = 0 for 5 cycles, then release with no requests;
  - response: `ledOut` = 000 and `clientGrant` = 00 during reset; after release, LED0 is high for phase 0–99 and 200–299 (cycles ~1–1000, ~2001–3000), and LED1/LED2 stay 0.
- Single owner:
  - stimulus: `clientReq` = 01, mode = {heartbeat, blink, on};
  - response: `clientGrant` = 01 within 11 cycles; LED0 constant 1; LED1 toggles every 5000 cycles.
- Preemption with gap:
  - stimulus: client 1 owns; client 0 asserts `clientReq`;
  - response: a 10-cycle window with `ledOut` = 000 and `clientGrant` = 00, then `clientGrant` = 01.
- Inter-tick glitch:
  - stimulus: client 0 pulses `clientReq` for 3 cycles, not spanning a tick;
  - response: `clientGrant` never changes.
- Mid-operation reset:
  - stimulus: `resetN` = 0 for 1 cycle while in GAP;
  - response: next cycle `ledOut` = 000, `clientGrant` = 00, phase = 0.
- PWM (with `OC_LED_CTRL_PWM_EN`):
  - stimulus: `ledBrightness` = 64 with an LED in mode on;
  - response: the lit LED is high 64 of every 256 cycles.

Source files
------------

// File: rtl/oc_led_ctrl_pkg.sv
// oc_led_ctrl_pkg
//   Shared types and constants for the LED bank controller.
//   - led_mode_e : per-LED display mode requested by a client
//   - state_e    : ownership state (the owning client index lives in its own register)
//   - phase limits for the 1 s frame made of 1 ms ticks
//   - mode_lit   : maps a mode plus the current waves to a lit/unlit level
package oc_led_ctrl_pkg;

   typedef enum logic [1:0] {
      LedModeOff       = 2'd0,
      LedModeOn        = 2'd1,
      LedModeBlink     = 2'd2,
      LedModeHeartbeat = 2'd3
   } led_mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn  = 2'd1,
      StGap  = 2'd2
   } state_e;

   // Phase is counted in ticks (1 ms each) within a 1000-tick frame.
   localparam int unsigned PhaseFrame      = 1000;
   localparam int unsigned PhaseBlinkEnd   = 500;
   localparam int unsigned PhaseBeat1End   = 100;
   localparam int unsigned PhaseBeat2Start = 200;
   localparam int unsigned PhaseBeat2End   = 300;
   localparam int unsigned PhaseWidth      = 10;

   function automatic logic mode_lit(led_mode_e mode, logic blink_wave, logic heartbeat_wave);
      logic lit;
      lit = 1'b0;
      case (mode)
         LedModeOff:       lit = 1'b0;
         LedModeOn:        lit = 1'b1;
         LedModeBlink:     lit = blink_wave;
         LedModeHeartbeat: lit = heartbeat_wave;
         default:          lit = 1'b0;
      endcase
      return lit;
   endfunction

endpackage

// File: rtl/oc_led_ctrl_if.sv
// oc_led_ctrl_if
//   Client-facing and LED-facing signal bundle of oc_led_ctrl.
//   - clientReq     : client i requests LED ownership while high
//   - clientMode    : [client][led] 2-bit mode (off, on, blink, heartbeat)
//   - clientGrant   : one-hot owner indication, zero when unowned or in gap
//   - ledBrightness : global brightness (used only when PWM is built in)
//   - ledOut        : to the LED output buffers, high = lit
//   Modports: master drives requests/modes/brightness, slave is the controller.
interface oc_led_ctrl_if #(
   parameter int unsigned LedCount    = 3,
   parameter int unsigned ClientCount = 2,
   parameter int unsigned PwmBits     = 8
);

   logic [ClientCount-1:0]                     clientReq;
   logic [ClientCount-1:0][LedCount-1:0][1:0] clientMode;
   logic [ClientCount-1:0]                     clientGrant;
   logic [PwmBits-1:0]                         ledBrightness;
   logic [LedCount-1:0]                        ledOut;

   modport master (
      output clientReq,
      output clientMode,
      output ledBrightness,
      input  clientGrant,
      input  ledOut
   );

   modport slave (
      input  clientReq,
      input  clientMode,
      input  ledBrightness,
      output clientGrant,
      output ledOut
   );

endinterface

// File: rtl/oc_led_pattern.sv
// oc_led_pattern
//   1 ms tick generator and 1 s phase counter for the LED controller.
//   Ports:
//   - clock, resetN : clock and synchronous active-low reset
//   - tick          : one-cycle pulse each ClockHz/1000 cycles
//   - blinkWave     : high for the first half of the frame
//   - heartbeatWave : high for phases [0,99] and [200,299]
//   The waves are decoded from the phase value that takes effect at the next edge, so a
//   registered consumer shows a boundary crossing on the cycle right after the tick.
module oc_led_pattern
   import oc_led_ctrl_pkg::*;
#(
   parameter int unsigned ClockHz = 156250000
) (
   input  logic clock,
   input  logic resetN,
   output logic tick,
   output logic blinkWave,
   output logic heartbeatWave
);

   localparam int unsigned TickPeriod = ClockHz / 1000;
   localparam int unsigned TickWidth  = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
   localparam logic [TickWidth-1:0]  TickLast  = TickWidth'(TickPeriod - 1);
   localparam logic [PhaseWidth-1:0] PhaseLast = PhaseWidth'(PhaseFrame - 1);

   logic [TickWidth-1:0]  tick_count_q, tick_count_d;
   logic [PhaseWidth-1:0] phase_q, phase_d;

   assign tick = (tick_count_q == TickLast);

   always_comb begin
      tick_count_d = tick ? '0 : tick_count_q + TickWidth'(1);
      phase_d      = phase_q;
      if (tick) begin
         phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseWidth'(1);
      end
   end

   always_comb begin
      blinkWave     = (phase_d < PhaseWidth'(PhaseBlinkEnd));
      heartbeatWave = (phase_d < PhaseWidth'(PhaseBeat1End)) ||
                      ((phase_d >= PhaseWidth'(PhaseBeat2Start)) &&
                       (phase_d <  PhaseWidth'(PhaseBeat2End)));
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         tick_count_q <= '0;
         phase_q      <= '0;
      end else begin
         tick_count_q <= tick_count_d;
         phase_q      <= phase_d;
      end
   end

endmodule

// File: rtl/oc_led_ctrl.sv
// oc_led_ctrl
//   Shares the board status LED bank among ClientCount requesters. The lowest-index
//   requester wins; ownership is re-evaluated only on 1 ms ticks, and a change of owner
//   (or release) passes through a one-tick dark GAP. Unowned, LED 0 shows a heartbeat.
//   Ports:
//   - clock, resetN : clock and synchronous active-low reset
//   - bus           : oc_led_ctrl_if slave (requests, modes, brightness, grant, LEDs)
//   Build option: define OC_LED_CTRL_PWM_EN to gate lit LEDs with a free-running
//   PwmBits counter against ledBrightness; otherwise lit LEDs are solid on.
module oc_led_ctrl
   import oc_led_ctrl_pkg::*;
#(
   parameter int unsigned ClockHz     = 156250000,
   parameter int unsigned LedCount    = 3,
   parameter int unsigned ClientCount = 2,
   parameter int unsigned PwmBits     = 8
) (
   input  logic          clock,
   input  logic          resetN,
   oc_led_ctrl_if.slave  bus
);

   localparam int unsigned OwnerWidth = (ClientCount > 1) ? $clog2(ClientCount) : 1;

   logic tick;
   logic blink_wave;
   logic heartbeat_wave;

   oc_led_pattern #(
      .ClockHz(ClockHz)
   ) u_pattern (
      .clock        (clock),
      .resetN       (resetN),
      .tick         (tick),
      .blinkWave    (blink_wave),
      .heartbeatWave(heartbeat_wave)
   );

   // ---------------------------------------------------------------------------------------
   // Fixed-priority arbitration
   // ---------------------------------------------------------------------------------------
   logic                  any_req;
   logic [OwnerWidth-1:0] winner;

   always_comb begin
      any_req = |bus.clientReq;
      winner  = '0;
      // Scan downwards so the lowest-index requester is the last to assign.
      for (int i = ClientCount - 1; i >= 0; i--) begin
         if (bus.clientReq[i]) begin
            winner = OwnerWidth'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Ownership FSM
   // ---------------------------------------------------------------------------------------
   state_e                state_q, state_d;
   logic [OwnerWidth-1:0] owner_q, owner_d;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (tick) begin
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  state_d = StOwn;
                  owner_d = winner;
               end
            end
            StOwn: begin
               if (!any_req || (winner != owner_q)) begin
                  state_d = StGap;
               end
            end
            StGap: begin
               if (any_req) begin
                  state_d = StOwn;
                  owner_d = winner;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Brightness gate
   // ---------------------------------------------------------------------------------------
   logic pwm_gate;

`ifdef OC_LED_CTRL_PWM_EN
   logic [PwmBits-1:0] pwm_q;

   // All-ones brightness is full on; the counter alone would leave one dark slot.
   assign pwm_gate = (&bus.ledBrightness) || (pwm_q < bus.ledBrightness);

   always_ff @(posedge clock) begin
      if (!resetN) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_q + PwmBits'(1);
      end
   end
`else
   logic unused_brightness;

   assign unused_brightness = ^bus.ledBrightness;
   assign pwm_gate          = 1'b1;
`endif

   // ---------------------------------------------------------------------------------------
   // Output decode from the next state, so a tick decision shows on the following cycle
   // ---------------------------------------------------------------------------------------
   logic [LedCount-1:0]    lit;
   logic [LedCount-1:0]    led_d, led_q;
   logic [ClientCount-1:0] grant_d, grant_q;

   always_comb begin
      lit     = '0;
      grant_d = '0;
      case (state_d)
         StIdle: begin
            lit[0] = heartbeat_wave;
         end
         StOwn: begin
            grant_d[owner_d] = 1'b1;
            for (int j = 0; j < LedCount; j++) begin
               lit[j] = mode_lit(led_mode_e'(bus.clientMode[owner_d][j]), blink_wave,
                                 heartbeat_wave);
            end
         end
         default: begin
            lit = '0;
         end
      endcase
      led_d = lit & {LedCount{pwm_gate}};
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= StIdle;
         owner_q <= '0;
         led_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         led_q   <= led_d;
         grant_q <= grant_d;
      end
   end

   assign bus.ledOut      = led_q;
   assign bus.clientGrant = grant_q;

endmodule

// File: tb/tb_oc_led_ctrl.sv
// tb_oc_led_ctrl
//   Directed bench for oc_led_ctrl with ClockHz = 10000 (tick every 10 cycles).
//   A frame-level model (cycle index -> tick/phase/pwm by arithmetic, owner as an int)
//   predicts ledOut/clientGrant each cycle; literal checks pin key scenarios.
module tb_oc_led_ctrl;

   localparam int unsigned ClockHz     = 10000;
   localparam int unsigned LedCount    = 3;
   localparam int unsigned ClientCount = 2;
   localparam int unsigned PwmBits     = 8;

   logic clock;
   logic resetN;

   oc_led_ctrl_if #(
      .LedCount   (LedCount),
      .ClientCount(ClientCount),
      .PwmBits    (PwmBits)
   ) bus ();

   oc_led_ctrl #(
      .ClockHz    (ClockHz),
      .LedCount   (LedCount),
      .ClientCount(ClientCount),
      .PwmBits    (PwmBits)
   ) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------------------
   int           m_cyc   = 0;   // cycles since reset release
   int           m_own   = -1;  // -1 idle, -2 gap, k = owned by client k
   bit           m_valid = 1'b0;
   logic [2:0]   exp_led;
   logic [1:0]   exp_grant;

   function automatic logic hb_of(int ph);
      return (ph < 100) || (ph >= 200 && ph < 300);
   endfunction

   function automatic logic lit_of(int mode, int ph);
      case (mode)
         1:       return 1'b1;
         2:       return ph < 500;
         3:       return hb_of(ph);
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clock) begin
      int         w;
      int         ph;
      int         pw;
      bit         on;
      logic [2:0] led;
      logic [1:0] gr;
      m_valid = 1'b1;
      if (!resetN) begin
         m_cyc     = 0;
         m_own     = -1;
         exp_led   = '0;
         exp_grant = '0;
      end else begin
         if ((m_cyc % 10) == 9) begin
            w = -1;
            for (int k = ClientCount - 1; k >= 0; k--) begin
               if (bus.clientReq[k]) w = k;
            end
            if (m_own >= 0) m_own = (w == m_own) ? m_own : -2;
            else            m_own = w;
         end
         ph  = ((m_cyc + 1) / 10) % 1000;
         pw  = m_cyc % 256;
         led = '0;
         gr  = '0;
         if (m_own == -1) begin
            led[0] = hb_of(ph);
         end else if (m_own >= 0) begin
            gr[m_own] = 1'b1;
            for (int j = 0; j < LedCount; j++) begin
               led[j] = lit_of(int'(bus.clientMode[m_own][j]), ph);
            end
         end
`ifdef OC_LED_CTRL_PWM_EN
         on = (bus.ledBrightness == 8'hFF) || (pw < int'(bus.ledBrightness));
`else
         on = 1'b1;
`endif
         if (!on) led = '0;
         exp_led   = led;
         exp_grant = gr;
         m_cyc++;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      if (m_valid) begin
         check("model_ledOut", int'(bus.ledOut), int'(exp_led));
         check("model_clientGrant", int'(bus.clientGrant), int'(exp_grant));
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_grant(input string name, input logic [1:0] want, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clock);
         if (bus.clientGrant == want) found = 1'b1;
      end
      check(name, int'(found), 1);
   endtask

   initial begin
      int gap_cycles;
      bit reached;
      bit changed;
      int high_cnt;

      resetN            = 1'b0;
      bus.clientReq     = '0;
      bus.clientMode    = '0;
      bus.ledBrightness = 8'hFF;

      // Reset / idle
      step(5);
      check("reset_ledOut", int'(bus.ledOut), 0);
      check("reset_grant", int'(bus.clientGrant), 0);
      resetN = 1'b1;
      step(500);
      check("idle_phase50", int'(bus.ledOut), 1);
      step(1000);
      check("idle_phase150", int'(bus.ledOut), 0);
      step(1000);
      check("idle_phase250", int'(bus.ledOut), 1);
      step(600);

      // Single owner: LED0 on, LED1 blink, LED2 heartbeat
      bus.clientMode[0] = {2'd3, 2'd2, 2'd1};
      bus.clientMode[1] = {2'd1, 2'd1, 2'd1};
      bus.clientReq     = 2'b01;
      wait_grant("own0_grant", 2'b01, 11);
      step(100);
      check("own0_led0", int'(bus.ledOut[0]), 1);
      step(11000);

      // Handover to client 1 through a gap
      bus.clientReq = 2'b10;
      wait_grant("own1_grant", 2'b10, 25);
      step(3);
      check("own1_ledOut", int'(bus.ledOut), 7);

      // Preemption by client 0
      bus.clientReq = 2'b11;
      gap_cycles    = 0;
      reached       = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         @(negedge clock);
         if (bus.clientGrant == 2'b01) reached = 1'b1;
         else if (bus.clientGrant == 2'b00 && bus.ledOut == 3'b000) gap_cycles++;
      end
      check("preempt_reached", int'(reached), 1);
      check("preempt_gap_len", gap_cycles, 10);

      // Release to idle, then a short glitch between ticks
      bus.clientReq = 2'b00;
      step(30);
      check("release_idle_grant", int'(bus.clientGrant), 0);
      while ((m_cyc % 10) != 0) @(negedge clock);
      bus.clientReq = 2'b01;
      step(3);
      bus.clientReq = 2'b00;
      changed = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.clientGrant != 2'b00) changed = 1'b1;
      end
      check("glitch_grant_stable", int'(changed), 0);

      // Reset in the middle of a gap
      bus.clientReq = 2'b01;
      wait_grant("pre_gap_grant", 2'b01, 11);
      step(20);
      bus.clientReq = 2'b00;
      wait_grant("enter_gap", 2'b00, 11);
      step(3);
      resetN = 1'b0;
      step(1);
      check("gap_reset_ledOut", int'(bus.ledOut), 0);
      check("gap_reset_grant", int'(bus.clientGrant), 0);
      resetN = 1'b1;
      step(1);
      check("post_reset_phase0", int'(bus.ledOut), 1);
      step(999);
      check("post_reset_phase100", int'(bus.ledOut), 0);

      // Brightness
      bus.clientMode[0] = {2'd1, 2'd1, 2'd1};
      bus.ledBrightness = 8'd64;
      bus.clientReq     = 2'b01;
      wait_grant("pwm_grant", 2'b01, 11);
      step(2);
      high_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clock);
         if (bus.ledOut[0]) high_cnt++;
      end
`ifdef OC_LED_CTRL_PWM_EN
      check("pwm_duty64", high_cnt, 64);
`else
      check("pwm_duty_solid", high_cnt, 256);
`endif
      bus.ledBrightness = 8'hFF;
      step(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
